program_trace_uart: RTL and testbench

- Downstream consumer of multiCycleMachine's programOut bus.
- Detects every change of programOut and queues the new word in a small FIFO.
- Serializes each queued word MSB-byte-first over a UART 8N1 transmit line for off-chip trace and debug.
- Lets a bench or board observe program execution without probing internal buses.

---
 rtl/program_trace_uart_pkg.sv | 10 +
 rtl/program_trace_uart_if.sv | 11 +
 rtl/program_trace_uart_trace_sync_fifo.sv | 39 +++
 rtl/program_trace_uart.sv | 104 ++++++++++
 tb/tb_program_trace_uart.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/program_trace_uart_pkg.sv
// program_trace_uart_pkg: shared widths, trace defaults and UART FSM state encodings
package program_trace_uart_pkg;
    localparam int INSTRUCTION_WIDTH = 16;
    localparam int TRACE_CLKS_PER_BIT = 4;
    localparam int TRACE_FIFO_DEPTH = 8;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;
    function automatic int bytes_for(input int w);
        return (w + 7) / 8;
    endfunction
endpackage

// File: rtl/program_trace_uart_if.sv
// program_trace_uart_if: trace bus (programOut, capture_en in; tx, busy, overflow, dropped_count out)
interface program_trace_uart_if #(parameter int W = 16);
    logic [W-1:0] programOut;
    logic capture_en;
    logic tx;
    logic busy;
    logic overflow;
    logic [7:0] dropped_count;
    modport master(output programOut, capture_en, input tx, busy, overflow, dropped_count);
    modport slave(input programOut, capture_en, output tx, busy, overflow, dropped_count);
endinterface

// File: rtl/program_trace_uart_trace_sync_fifo.sv
// trace_sync_fifo: sync FIFO (clk, async clear, push/pop, din, registered dout valid after pop edge, full/empty)
module trace_sync_fifo #(
    parameter int width = 16,
    parameter int depth = 8
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [width-1:0] din,
    output logic [width-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(depth);
    logic [width-1:0] mem [depth];
    logic [AW:0] wptr, rptr;
    logic wr, rd;
    assign empty = wptr == rptr;
    assign full = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign rd = pop & !empty;
    assign wr = push & (!full | rd);
    always_ff @(posedge clk) begin
        if (wr) mem[wptr[AW-1:0]] <= din;
    end
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            wptr <= '0;
            rptr <= '0;
            dout <= '0;
        end else begin
            if (wr) wptr <= wptr + 1'b1;
            if (rd) begin
                dout <= mem[rptr[AW-1:0]];
                rptr <= rptr + 1'b1;
            end
        end
    end
endmodule

// File: rtl/program_trace_uart.sv
// program_trace_uart: queues changes of programOut and sends them MSB-byte-first over UART 8N1 (clk, clear, bus slave)
module program_trace_uart
    import program_trace_uart_pkg::*;
#(
    parameter int INSTR_WIDTH = INSTRUCTION_WIDTH,
    parameter int CLKS_PER_BIT = TRACE_CLKS_PER_BIT,
    parameter int FIFO_DEPTH = TRACE_FIFO_DEPTH
) (
    input logic clk,
    input logic clear,
    program_trace_uart_if.slave bus
);
    localparam int BYTES = bytes_for(INSTR_WIDTH);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam int BW = $clog2(BYTES + 1);
    logic [INSTR_WIDTH-1:0] prev, word;
    logic primed, push, pop, full, empty, tx, overflow, bit_end, last_byte;
    logic [7:0] dropped_count, cur;
    logic [BYTES*8-1:0] ext;
    uart_state_t state;
    logic [CW-1:0] cnt;
    logic [2:0] bit_idx;
    logic [BW-1:0] byte_idx;
    assign push = bus.capture_en & (!primed | (bus.programOut != prev));
    assign pop = (state == IDLE) & !empty;
    assign ext = (BYTES*8)'(word);
    assign cur = 8'(ext >> (8 * (BYTES - 1 - int'(byte_idx))));
    assign bit_end = cnt == CW'(CLKS_PER_BIT - 1);
    assign last_byte = byte_idx == BW'(BYTES - 1);
    assign bus.tx = tx;
    assign bus.busy = !empty | (state != IDLE);
    assign bus.overflow = overflow;
    assign bus.dropped_count = dropped_count;
    trace_sync_fifo #(.width(INSTR_WIDTH), .depth(FIFO_DEPTH)) fifo (
        .clk(clk),
        .clear(clear),
        .push(push),
        .pop(pop),
        .din(bus.programOut),
        .dout(word),
        .full(full),
        .empty(empty)
    );
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            prev <= '0;
            primed <= 1'b0;
            overflow <= 1'b0;
            dropped_count <= '0;
        end else begin
            prev <= bus.programOut;
            primed <= 1'b1;
            if (push & full & !pop) begin
                overflow <= 1'b1;
                dropped_count <= dropped_count + 8'(dropped_count != 8'hff);
            end
        end
    end
    // The FIFO's registered dout holds the popped word for the whole frame; tx is set one bit ahead at each bit boundary.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state <= IDLE;
            tx <= 1'b1;
            cnt <= '0;
            bit_idx <= '0;
            byte_idx <= '0;
        end else begin
            case (state)
                IDLE: begin
                    tx <= empty;
                    if (!empty) begin
                        state <= START;
                        cnt <= '0;
                        byte_idx <= '0;
                    end
                end
                START: begin
                    cnt <= bit_end ? '0 : cnt + 1'b1;
                    if (bit_end) begin
                        state <= DATA;
                        bit_idx <= '0;
                        tx <= cur[0];
                    end
                end
                DATA: begin
                    cnt <= bit_end ? '0 : cnt + 1'b1;
                    if (bit_end) begin
                        state <= (bit_idx == 3'd7) ? STOP : DATA;
                        bit_idx <= bit_idx + 3'd1;
                        tx <= (bit_idx == 3'd7) ? 1'b1 : cur[bit_idx + 3'd1];
                    end
                end
                default: begin
                    cnt <= bit_end ? '0 : cnt + 1'b1;
                    if (bit_end) begin
                        state <= last_byte ? IDLE : START;
                        byte_idx <= last_byte ? byte_idx : byte_idx + 1'b1;
                        tx <= last_byte;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_program_trace_uart.sv
// tb_program_trace_uart: randomized and directed checks of program_trace_uart against a queue-based frame model
module tb_program_trace_uart;
    import program_trace_uart_pkg::*;
    localparam int W = 16;
    localparam int CPB = 4;
    localparam int DEPTH = 8;
    localparam int BYTES = (W + 7) / 8;
    localparam int FRAME = BYTES * 10 * CPB;
    logic clk = 1'b0;
    logic clear = 1'b0;
    program_trace_uart_if #(.W(W)) bus();
    program_trace_uart #(.INSTR_WIDTH(W), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk),
        .clear(clear),
        .bus(bus)
    );
    always #5 clk = ~clk;
    int total = 0;
    int bad = 0;
    logic [W-1:0] m_prev, m_word;
    logic [W-1:0] m_q[$];
    logic m_primed, m_active, m_ovf, m_push, m_pop, m_full;
    int m_t, m_dc;
    int m_frames = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    // Line level t cycles after the pop edge: 10 bits per byte, MSB byte first, data LSB first.
    function automatic logic frame_bit(input logic [W-1:0] w, input int t);
        int pos = t / CPB;
        int b = pos / 10;
        int k = pos % 10;
        logic [BYTES*8-1:0] e = (BYTES*8)'(w);
        logic [7:0] by = 8'(e >> (8 * (BYTES - 1 - b)));
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return by[k-1];
    endfunction
    task automatic model_step();
        if (clear) begin
            m_prev = '0;
            m_primed = 1'b0;
            m_q.delete();
            m_active = 1'b0;
            m_t = 0;
            m_ovf = 1'b0;
            m_dc = 0;
        end else begin
            m_push = bus.capture_en && (!m_primed || bus.programOut != m_prev);
            m_prev = bus.programOut;
            m_primed = 1'b1;
            m_full = m_q.size() == DEPTH;
            m_pop = !m_active && m_q.size() > 0;
            if (m_active) begin
                m_t++;
                if (m_t == FRAME) m_active = 1'b0;
            end else if (m_pop) begin
                m_word = m_q.pop_front();
                m_active = 1'b1;
                m_t = 0;
                m_frames++;
            end
            if (m_push) begin
                if (m_full && !m_pop) begin
                    m_ovf = 1'b1;
                    if (m_dc < 255) m_dc++;
                end else m_q.push_back(bus.programOut);
            end
        end
    endtask
    initial forever begin
        @(posedge clk or posedge clear);
        model_step();
    end
    initial forever begin
        @(negedge clk);
        chk("tx", bus.tx, m_active ? frame_bit(m_word, m_t) : 1'b1);
        chk("busy", bus.busy, m_active || m_q.size() != 0);
        chk("overflow", bus.overflow, m_ovf);
        chk("dropped_count", bus.dropped_count, m_dc);
    end
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask
    initial begin
        logic [19:0] seq;
        logic [W-1:0] v;
        int f0, n;
        seq = 20'b0101001011_0110000111;
        bus.capture_en = 1'b0;
        bus.programOut = '0;
        #1 clear = 1'b1;
        step(3);
        chk("rst_tx", bus.tx, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_ovf", bus.overflow, 0);
        chk("rst_dc", bus.dropped_count, 0);
        clear = 1'b0;
        f0 = m_frames;
        bus.programOut = 16'hA5C3;
        bus.capture_en = 1'b1;
        step(1);
        n = 0;
        while (bus.tx !== 1'b0 && n < 10) begin
            step(1);
            n++;
        end
        chk("single_start", bus.tx, 0);
        for (int i = 0; i < 80; i++) begin
            chk("single_bit", bus.tx, seq[19 - i / 4]);
            step(1);
        end
        chk("single_idle_busy", bus.busy, 0);
        step(300);
        chk("static_busy", bus.busy, 0);
        chk("static_frames", m_frames - f0, 1);
        f0 = m_frames;
        for (int i = 0; i < 20; i++) begin
            bus.programOut = 16'h1000 + 16'(i);
            step(1);
        end
        chk("ovf_flag", bus.overflow, 1);
        chk("ovf_count", bus.dropped_count, 11);
        chk("ovf_model_count", m_dc, 11);
        step(9 * (FRAME + 1) + 20);
        chk("ovf_frames", m_frames - f0, 9);
        chk("ovf_drained", bus.busy, 0);
        bus.capture_en = 1'b0;
        bus.programOut = 16'h0001;
        step(1);
        bus.programOut = 16'h0002;
        step(1);
        bus.programOut = 16'h0003;
        step(1);
        f0 = m_frames;
        bus.capture_en = 1'b1;
        step(50);
        chk("gate_busy", bus.busy, 0);
        chk("gate_frames", m_frames - f0, 0);
        bus.programOut = 16'h0004;
        step(FRAME + 20);
        chk("gate_one_frame", m_frames - f0, 1);
        bus.programOut = 16'h5555;
        step(30);
        #1 clear = 1'b1;
        #1;
        chk("midclr_tx", bus.tx, 1);
        chk("midclr_busy", bus.busy, 0);
        chk("midclr_ovf", bus.overflow, 0);
        chk("midclr_dc", bus.dropped_count, 0);
        bus.capture_en = 1'b0;
        step(3);
        clear = 1'b0;
        for (int i = 0; i < 100; i++) begin
            chk("midclr_quiet", bus.tx, 1);
            step(1);
        end
        bus.capture_en = 1'b1;
        v = bus.programOut;
        for (int i = 0; i < 320; i++) begin
            v = v ^ 16'(1 + $urandom_range(0, 65534));
            bus.programOut = v;
            step(1);
        end
        chk("sat_count", bus.dropped_count, 255);
        chk("sat_ovf", bus.overflow, 1);
        step(20);
        chk("sat_hold", bus.dropped_count, 255);
        #1 clear = 1'b1;
        #1;
        chk("sat_clr_ovf", bus.overflow, 0);
        chk("sat_clr_dc", bus.dropped_count, 0);
        step(2);
        clear = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 3) bus.programOut = 16'($urandom);
            if ($urandom_range(0, 199) == 0) bus.capture_en = !bus.capture_en;
            step(1);
        end
        bus.capture_en = 1'b0;
        step((FRAME + 1) * (DEPTH + 1) + 20);
        chk("rand_drained", bus.busy, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
